alu_addsub_pipe: RTL and testbench
==================================

# alu_addsub_pipe

Parametrised, two-stage pipelined carry-lookahead adder/subtractor with signed or unsigned saturation, result flags and a valid/ready handshake. It is the next-generation adder for the ALU datapath. It handles widths beyond 16 bits, so the carry chain is split across a register boundary to meet timing. The upstream issue logic drives it, and the writeback/flag logic consumes it.

## Interface
- `WIDTH`, 16: operand width; must be a multiple of 2*`GROUP`.
- `GROUP`, 4: carry-lookahead group size in bits. Block P/G is computed per group, and group carries come from a second-level lookahead.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `in_valid`  in  1  operand transfer request.
- `in_ready`  out  1  block can accept operands; a transfer occurs when `in_valid && in_ready`.
- `a`, `b`  in  `WIDTH`  operands.
- `sub`  in  1  selects the operation: 0 = a+b, 1 = a-b.
- `sat`  in  1  1 = saturate the result on overflow; 0 = wrap.
- `uns`  in  1  1 = unsigned overflow/saturation rules; 0 = two's-complement rules.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result; a transfer occurs when `out_valid && out_ready`.
- `sum`  out  `WIDTH`  result after saturation.
- `ovfl`  out  1  overflow under the selected signed/unsigned rule.
- `cout`  out  1  raw carry out of the MSB. For subtraction, 1 means no borrow.
- `zero`  out  1  `sum` == 0 (after saturation).
- `sticky_ovfl`  out  1  (only with `ALU_STICKY_OVFL_EN`) accumulated overflow.
- `sticky_clr`  in  1  (only with `ALU_STICKY_OVFL_EN`) synchronous clear of `sticky_ovfl`.

## Operation
- Operand preparation: b' = `sub` ? ~b : b; carry-in = `sub`.
- Stage 1 (on input transfer):
  - Compute the lower `WIDTH`/2 bits using group CLA.
  - Register the lower sum, the carry into bit `WIDTH`/2, the upper halves of a and b', and `sub`/`sat`/`uns`.
- Stage 2:
  - Compute the upper half from the registered carry.
  - Compute the raw sum S, `cout`, overflow and saturation; register these into the output registers.
- Signed overflow (`uns`=0): the operand signs (a, b') are equal and S[MSB] differs from them.
  - With `sat`=1: S[MSB]=1 → 0111…1; S[MSB]=0 → 1000…0.
- Unsigned overflow (`uns`=1):
  - Add: `cout`=1; with `sat`=1 the result is all ones.
  - Sub: `cout`=0 (borrow); with `sat`=1 the result is all zeros.
- With `sat`=0, `sum` = S (wrapped) and `ovfl` is still reported.
- `zero` is computed on the final `sum`.
- Handshake, with v1/v2 as the stage valid bits:
  - s2_adv = !v2 || `out_ready`.
  - `in_ready` = !v1 || s2_adv.
  - Stage 1 moves to stage 2 when v1 && s2_adv.
- Full throughput is one operation per cycle. There are no bubbles when `out_ready` is held high.
- While `out_valid && !out_ready`: `sum`/`ovfl`/`cout`/`zero` hold stable. Stage 1 may still fill if it is empty.
- Ordering is strict FIFO. No result may be lost or duplicated.

## Timing
- Reset values: v1 = v2 = 0; `out_valid` = 0; `in_ready` = 1; `sum` = 0; `ovfl` = `cout` = 0; `zero` = 0; `sticky_ovfl` = 0.
- Latency is 2: operands transferred at edge N appear with `out_valid`=1 after edge N+1, i.e. for the result ready at edge N+2.
- `in_ready` is combinational from `out_ready` and the state; no other combinational input-to-output paths exist.
- Simultaneous input transfer and output transfer while both stages are full: accepted. The pipeline shifts by one.
- Reset asserted mid-operation: `out_valid` drops immediately (asynchronously) and in-flight operations are discarded. Nothing is emitted after release until new input arrives.
- Changes on `sub`/`sat`/`uns` affect only the operation transferred with them; they are captured per transaction.

## Configuration
- Macro: `ALU_STICKY_OVFL_EN`.
- Defined:
  - `sticky_ovfl`/`sticky_clr` ports exist.
  - `sticky_ovfl` sets on any output transfer with `ovfl`=1.
  - `sticky_clr` clears it on the next edge.
  - A simultaneous set and clear leaves it at 1 (the new event wins).
- Undefined: both ports and the register are absent. All other behaviour is identical.

## Test plan
(All scenarios use `WIDTH`=16, `GROUP`=4.)
- Signed add, saturation and cross-half carry:
  - 0x7FFF+0x0001, `sat`=1 → `sum`=0x7FFF, `ovfl`=1.
  - Same with `sat`=0 → 0x8000, `ovfl`=1.
  - 0x00FF+0x0001 → 0x0100, `ovfl`=0 (carry crosses the stage boundary).
- Signed subtract:
  - 0x8000−0x0001, `sat`=1 → 0x8000, `ovfl`=1, `cout`=1.
  - 0x0003−0x0003 → 0x0000, `zero`=1, `cout`=1.
- Unsigned, `uns`=1, `sat`=1:
  - 0xFFF0+0x0020 → 0xFFFF, `ovfl`=1, `cout`=1.
  - 0x0005−0x0007 → 0x0000, `ovfl`=1, `cout`=0, `zero`=1.
- Streaming: send 8 back-to-back operations with `out_ready` low for 3 cycles mid-stream.
  - `in_ready` falls once both stages are full.
  - All 8 results arrive in order, with no loss or duplication.
  - `sum` stays stable while stalled.
- Reset with 2 operations in flight: `rst_n` low → `out_valid`=0 immediately; no results appear after release.
- With `ALU_STICKY_OVFL_EN`: one overflowing transfer sets `sticky_ovfl`=1. `sticky_clr` pulsed in the same cycle as another overflowing transfer → stays 1. A clear alone → 0.

Source files
------------

// File: rtl/alu_addsub_pipe.sv
// Two-stage carry-lookahead add/sub with signed/unsigned saturation and flags; optional ALU_STICKY_OVFL_EN.
// Latency 2 cycles, one op per cycle; stalls hold outputs and backpressure in_ready when both stages are full.
module alu_addsub_pipe #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             sat,
    input  logic             uns,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             ovfl,
    output logic             cout,
    output logic             zero
`ifdef ALU_STICKY_OVFL_EN
    ,
    output logic             sticky_ovfl,
    input  logic             sticky_clr
`endif
);

    localparam int HW = WIDTH / 2;
    localparam int NG = HW / GROUP;

    // Group P/G per GROUP bits, group carries from a second-level lookahead,
    // then in-group carries rebuilt from each group's carry-in.
    function automatic logic [HW:0] cla(input logic [HW-1:0] x, input logic [HW-1:0] y,
                                        input logic cin);
        logic [HW-1:0] p, g, c;
        logic [NG:0]   gc;
        logic          gp, gg;
        p     = x ^ y;
        g     = x & y;
        c     = '0;
        gc    = '0;
        gc[0] = cin;
        for (int k = 0; k < NG; k++) begin
            gp = 1'b1;
            gg = 1'b0;
            for (int j = 0; j < GROUP; j++) begin
                gg = g[k*GROUP+j] | (p[k*GROUP+j] & gg);
                gp = gp & p[k*GROUP+j];
            end
            gc[k+1] = gg | (gp & gc[k]);
        end
        for (int k = 0; k < NG; k++) begin
            c[k*GROUP] = gc[k];
            for (int j = 1; j < GROUP; j++)
                c[k*GROUP+j] = g[k*GROUP+j-1] | (p[k*GROUP+j-1] & c[k*GROUP+j-1]);
        end
        return {gc[NG], p ^ c};
    endfunction

    logic          v1_q, v1_d, v2_q, v2_d;
    logic [HW-1:0] lo_sum_q, lo_sum_d;
    logic          c_mid_q, c_mid_d;
    logic [HW-1:0] a_hi_q, a_hi_d, b_hi_q, b_hi_d;
    logic          sub_q, sub_d, sat_q, sat_d, uns_q, uns_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic          ovfl_q, ovfl_d, cout_q, cout_d, zero_q, zero_d;

    logic          s2_adv, in_xfer, s1_move;
    logic [WIDTH-1:0] b_eff;
    logic [HW:0]   lo_res, hi_res;
    logic [WIDTH-1:0] raw;
    logic          s_ovfl, u_ovfl;

    assign s2_adv    = !v2_q || out_ready;
    assign in_ready  = !v1_q || s2_adv;
    assign in_xfer   = in_valid && in_ready;
    assign s1_move   = v1_q && s2_adv;
    assign out_valid = v2_q;
    assign sum       = sum_q;
    assign ovfl      = ovfl_q;
    assign cout      = cout_q;
    assign zero      = zero_q;

    always_comb begin
        b_eff    = sub ? ~b : b;
        lo_res   = cla(a[HW-1:0], b_eff[HW-1:0], sub);
        v1_d     = in_xfer ? 1'b1 : (s1_move ? 1'b0 : v1_q);
        lo_sum_d = lo_sum_q;
        c_mid_d  = c_mid_q;
        a_hi_d   = a_hi_q;
        b_hi_d   = b_hi_q;
        sub_d    = sub_q;
        sat_d    = sat_q;
        uns_d    = uns_q;
        if (in_xfer) begin
            lo_sum_d = lo_res[HW-1:0];
            c_mid_d  = lo_res[HW];
            a_hi_d   = a[WIDTH-1:HW];
            b_hi_d   = b_eff[WIDTH-1:HW];
            sub_d    = sub;
            sat_d    = sat;
            uns_d    = uns;
        end
    end

    always_comb begin
        hi_res = cla(a_hi_q, b_hi_q, c_mid_q);
        raw    = {hi_res[HW-1:0], lo_sum_q};
        s_ovfl = (a_hi_q[HW-1] == b_hi_q[HW-1]) && (raw[WIDTH-1] != a_hi_q[HW-1]);
        // For subtraction the carry out is "no borrow", so overflow is its absence.
        u_ovfl = sub_q ? ~hi_res[HW] : hi_res[HW];
        v2_d   = s2_adv ? v1_q : v2_q;
        sum_d  = sum_q;
        ovfl_d = ovfl_q;
        cout_d = cout_q;
        zero_d = zero_q;
        if (s1_move) begin
            ovfl_d = uns_q ? u_ovfl : s_ovfl;
            cout_d = hi_res[HW];
            sum_d  = raw;
            if (sat_q && ovfl_d) begin
                if (uns_q)
                    sum_d = sub_q ? '0 : '1;
                else
                    sum_d = raw[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
            end
            zero_d = (sum_d == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            v2_q     <= 1'b0;
            lo_sum_q <= '0;
            c_mid_q  <= 1'b0;
            a_hi_q   <= '0;
            b_hi_q   <= '0;
            sub_q    <= 1'b0;
            sat_q    <= 1'b0;
            uns_q    <= 1'b0;
            sum_q    <= '0;
            ovfl_q   <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            lo_sum_q <= lo_sum_d;
            c_mid_q  <= c_mid_d;
            a_hi_q   <= a_hi_d;
            b_hi_q   <= b_hi_d;
            sub_q    <= sub_d;
            sat_q    <= sat_d;
            uns_q    <= uns_d;
            sum_q    <= sum_d;
            ovfl_q   <= ovfl_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
        end
    end

`ifdef ALU_STICKY_OVFL_EN
    logic sticky_q, sticky_d;

    // A fresh overflow event takes priority over a concurrent clear.
    assign sticky_d    = (v2_q && out_ready && ovfl_q) | (sticky_q & ~sticky_clr);
    assign sticky_ovfl = sticky_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
`endif

endmodule

// File: tb/tb_alu_addsub_pipe.sv
// Scoreboard bench for alu_addsub_pipe at WIDTH=16, GROUP=4 with hand-computed expected results.
module tb_alu_addsub_pipe;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovfl;
        logic        cout;
        logic        zero;
    } res_t;

    logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        sub, sat, uns, ovfl, cout, zero;
`ifdef ALU_STICKY_OVFL_EN
    logic        sticky_ovfl, sticky_clr;
`endif

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t held;
    logic held_vld = 1'b0;
    logic saw_in_ready_low = 1'b0;

    alu_addsub_pipe #(.WIDTH(16), .GROUP(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .sat(sat), .uns(uns),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .ovfl(ovfl), .cout(cout), .zero(zero)
`ifdef ALU_STICKY_OVFL_EN
        , .sticky_ovfl(sticky_ovfl), .sticky_clr(sticky_clr)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0b want %0b", name, got, want);
        end
    endtask

    // Monitor: pops the scoreboard on every output transfer and checks hold-stability while stalled.
    always @(negedge clk) begin
        res_t got;
        got = '{sum: sum, ovfl: ovfl, cout: cout, zero: zero};
        if (rst_n && !in_ready) saw_in_ready_low = 1'b1;
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output sum %h ovfl %b cout %b zero %b", sum, ovfl, cout, zero);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL result got sum %h ovfl %b cout %b zero %b want sum %h ovfl %b cout %b zero %b",
                             got.sum, got.ovfl, got.cout, got.zero, e.sum, e.ovfl, e.cout, e.zero);
                end
            end
        end
        if (rst_n && out_valid && !out_ready) begin
            if (held_vld) begin
                checks++;
                if (got !== held) begin
                    errors++;
                    $display("FAIL stall_hold got %h want %h", got, held);
                end
            end
            held     = got;
            held_vld = 1'b1;
        end else begin
            held_vld = 1'b0;
        end
    end

    task automatic send(input logic [15:0] av, input logic [15:0] bv, input logic s,
                        input logic st, input logic u, input res_t e);
        int n;
        in_valid = 1'b1; a = av; b = bv; sub = s; sat = st; uns = u;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready got 0 want 1");
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout pending got %0d want 0", exp_q.size());
        end
    endtask

    logic [15:0] st_a[8] = '{16'h0001, 16'h1234, 16'hFFFF, 16'h4000, 16'h0010, 16'hFF00, 16'h2222, 16'h8000};
    logic [15:0] st_b[8] = '{16'h0001, 16'h1111, 16'h0001, 16'h4000, 16'h0008, 16'h0100, 16'h3333, 16'h8000};
    res_t        st_e[8] = '{'{16'h0002, 1'b0, 1'b0, 1'b0}, '{16'h2345, 1'b0, 1'b0, 1'b0},
                             '{16'h0000, 1'b0, 1'b1, 1'b1}, '{16'h8000, 1'b1, 1'b0, 1'b0},
                             '{16'h0018, 1'b0, 1'b0, 1'b0}, '{16'h0000, 1'b0, 1'b1, 1'b1},
                             '{16'h5555, 1'b0, 1'b0, 1'b0}, '{16'h0000, 1'b1, 1'b1, 1'b1}};

    initial begin
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; sub = 1'b0; sat = 1'b0; uns = 1'b0;
`ifdef ALU_STICKY_OVFL_EN
        sticky_clr = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_in_ready", in_ready, 1'b1);
        checks++;
        if (sum !== 16'h0000) begin errors++; $display("FAIL rst_sum got %h want 0000", sum); end
        check1("rst_ovfl", ovfl, 1'b0);
        check1("rst_cout", cout, 1'b0);
        check1("rst_zero", zero, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors, first one also checks the two-cycle latency.
        send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b0, '{16'h7FFF, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        check1("latency_early", out_valid, 1'b0);
        @(negedge clk);
        check1("latency_n2", out_valid, 1'b1);
        @(posedge clk); #1;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b0});
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0, 1'b0});
        send(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0});
        send(16'h0003, 16'h0003, 1'b1, 1'b0, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b1});
        send(16'hFFF0, 16'h0020, 1'b0, 1'b1, 1'b1, '{16'hFFFF, 1'b1, 1'b1, 1'b0});
        send(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, '{16'h0000, 1'b1, 1'b0, 1'b1});
        send(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1, '{16'h0002, 1'b0, 1'b1, 1'b0});
        drain();

        // Streaming with a 3-cycle consumer stall mid-stream.
        saw_in_ready_low = 1'b0;
        fork
            for (int i = 0; i < 8; i++)
                send(st_a[i], st_b[i], 1'b0, 1'b0, 1'b0, st_e[i]);
            begin
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check1("stream_in_ready_fell", saw_in_ready_low, 1'b1);

        // Reset with two operations in flight.
        out_ready = 1'b0;
        send(16'h1111, 16'h1111, 1'b0, 1'b0, 1'b0, '{16'h2222, 1'b0, 1'b0, 1'b0});
        send(16'h2222, 16'h2222, 1'b0, 1'b0, 1'b0, '{16'h4444, 1'b0, 1'b0, 1'b0});
        check1("inflight_out_valid", out_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check1("async_reset_out_valid", out_valid, 1'b0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check1("no_output_after_reset", seen, 1'b0);
        @(posedge clk); #1;

`ifdef ALU_STICKY_OVFL_EN
        check1("sticky_after_reset", sticky_ovfl, 1'b0);
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b0});
        drain();
        check1("sticky_set", sticky_ovfl, 1'b1);
        out_ready = 1'b0;
        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{16'h8000, 1'b1, 1'b0, 1'b0});
        @(posedge clk); #1;
        sticky_clr = 1'b1;
        out_ready  = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check1("sticky_set_wins", sticky_ovfl, 1'b1);
        sticky_clr = 1'b1;
        @(posedge clk); #1;
        sticky_clr = 1'b0;
        check1("sticky_clear", sticky_ovfl, 1'b0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
